// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets at power-on, then releases them one at a
// time in ascending index order, waiting for each domain's synchronized acknowledge.
module rst_seq_ctrl #(
  parameter int NUM_DOM     = 3,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_W       = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_DOM-1:0] SW_RST_REQ,
  input  logic [GAP_W-1:0]   GAP_CFG,
  input  logic [NUM_DOM-1:0] DOM_ACK,
  output logic [NUM_DOM-1:0] DOM_RST_N,
  output logic               SEQ_BUSY,
  output logic               SEQ_DONE,
  output logic               TIMEOUT_ERR
);

  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int CNT_MAX = (STRETCH_CYC > TIMEOUT_CYC) ? STRETCH_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOM - 1);
  localparam logic [CNT_W-1:0] STRETCH_END = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_STRETCH,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_RUN
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [GAP_W-1:0]   gap_left, gap_nx;
  logic [NUM_DOM-1:0] rst_n_q, rst_n_nx;
  logic               err_q, err_nx;
  logic [NUM_DOM-1:0] sync_q [SYNC_STAGES];
  logic [NUM_DOM-1:0] ack_s;
  logic [IDX_W-1:0]   req_k;
  logic               acked;
  logic               adv;

  // Acks arrive from other clock domains; only the last synchronizer stage is trusted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= DOM_ACK;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_STRETCH;
      idx      <= '0;
      cnt      <= '0;
      gap_left <= '0;
      rst_n_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      gap_left <= gap_nx;
      rst_n_q  <= rst_n_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    gap_nx   = gap_left;
    rst_n_nx = rst_n_q;
    err_nx   = err_q;
    acked    = 1'b0;
    adv      = 1'b0;
    req_k    = '0;

    // Scanning downward leaves the lowest requested index in req_k.
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (SW_RST_REQ[i]) req_k = IDX_W'(i);
    end

    case (state)
      ST_STRETCH: begin
        if (cnt == STRETCH_END) begin
          state_nx = ST_RELEASE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        rst_n_nx[idx] = 1'b1;
        state_nx      = ST_WAIT_ACK;
        cnt_nx        = '0;
      end
      ST_WAIT_ACK: begin
        if (ack_s[idx]) begin
          acked = 1'b1;
        end else if (cnt == TIMEOUT_END) begin
          err_nx = 1'b1;
          acked  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
        if (acked) begin
          cnt_nx = '0;
          if (GAP_CFG == '0) begin
            adv = 1'b1;
          end else begin
            state_nx = ST_GAP;
            gap_nx   = GAP_CFG;
          end
        end
      end
      ST_GAP: begin
        if (gap_left <= GAP_W'(1)) adv = 1'b1;
        else gap_nx = gap_left - GAP_W'(1);
      end
      ST_RUN: begin
        if (|SW_RST_REQ) begin
          for (int i = 0; i < NUM_DOM; i++) begin
            if (i >= int'(req_k)) rst_n_nx[i] = 1'b0;
          end
          idx_nx   = req_k;
          cnt_nx   = '0;
          state_nx = ST_STRETCH;
        end
      end
      default: begin
        state_nx = ST_STRETCH;
      end
    endcase

    // Shared exit from WAIT_ACK/GAP: either move on to the next domain or finish.
    if (adv) begin
      if (idx == LAST_IDX) begin
        state_nx = ST_RUN;
      end else begin
        idx_nx   = idx + IDX_W'(1);
        state_nx = ST_RELEASE;
      end
    end
  end

  assign DOM_RST_N   = rst_n_q;
  assign TIMEOUT_ERR = err_q;
  assign SEQ_DONE    = (state == ST_RUN);
  assign SEQ_BUSY    = (state != ST_RUN);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected DOM_RST_N changes (value and edge number)
// are queued as stimulus is applied and matched by a monitor as the DUT produces them.
module tb_rst_seq_ctrl;

  localparam int NUM_DOM     = 3;
  localparam int STRETCH_CYC = 4;
  localparam int GAP_W       = 8;
  localparam int TIMEOUT_CYC = 8;
  localparam int SYNC_STAGES = 2;

  logic               CLK;
  logic               RST;
  logic [NUM_DOM-1:0] SW_RST_REQ;
  logic [GAP_W-1:0]   GAP_CFG;
  logic [NUM_DOM-1:0] DOM_ACK;
  logic [NUM_DOM-1:0] DOM_RST_N;
  logic               SEQ_BUSY;
  logic               SEQ_DONE;
  logic               TIMEOUT_ERR;
  logic [NUM_DOM-1:0] ack_en;

  typedef struct packed {
    logic [NUM_DOM-1:0] val;
    int                 at_cyc;
  } ev_t;

  ev_t                exp_q[$];
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;
  int                 base;
  int                 e;
  int                 lat;
  logic [NUM_DOM-1:0] prev_rst_n = '0;

  rst_seq_ctrl #(
    .NUM_DOM    (NUM_DOM),
    .STRETCH_CYC(STRETCH_CYC),
    .GAP_W      (GAP_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .GAP_CFG    (GAP_CFG),
    .DOM_ACK    (DOM_ACK),
    .DOM_RST_N  (DOM_RST_N),
    .SEQ_BUSY   (SEQ_BUSY),
    .SEQ_DONE   (SEQ_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // Each domain acknowledges by echoing its own reset release, unless masked off.
  assign DOM_ACK = DOM_RST_N & ack_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input logic [NUM_DOM-1:0] val, input int at);
    ev_t ev;
    ev.val    = val;
    ev.at_cyc = at;
    exp_q.push_back(ev);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  // Every observed change of DOM_RST_N must match the next queued expectation.
  always @(negedge CLK) begin : monitor
    ev_t ev;
    if (DOM_RST_N !== prev_rst_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rst_n_change", 32'(DOM_RST_N), 32'(prev_rst_n));
      end else begin
        ev = exp_q.pop_front();
        check("rst_n_value", 32'(DOM_RST_N), 32'(ev.val));
        check("rst_n_cycle", 32'(cyc), 32'(ev.at_cyc));
      end
      prev_rst_n = DOM_RST_N;
    end
  end

  initial begin
    RST        = 1'b0;
    SW_RST_REQ = '0;
    GAP_CFG    = 8'd2;
    ack_en     = '1;

    // Power-on: all held in reset, then released 001, 011, 111.
    repeat (3) @(negedge CLK);
    check("reset_rst_n", 32'(DOM_RST_N), 32'h0);
    check("reset_busy", 32'(SEQ_BUSY), 32'h1);
    check("reset_done", 32'(SEQ_DONE), 32'h0);
    check("reset_err", 32'(TIMEOUT_ERR), 32'h0);
    RST  = 1'b1;
    base = cyc;
    lat  = 2 + SYNC_STAGES + 2;
    push(3'b001, base + STRETCH_CYC + 1);
    push(3'b011, base + STRETCH_CYC + 1 + lat);
    push(3'b111, base + STRETCH_CYC + 1 + 2 * lat);
    wait_to(base + STRETCH_CYC + 2 * lat + lat - 1);
    check("po_done_early", 32'(SEQ_DONE), 32'h0);
    wait_to(base + STRETCH_CYC + 2 * lat + lat);
    check("po_done", 32'(SEQ_DONE), 32'h1);
    check("po_busy", 32'(SEQ_BUSY), 32'h0);
    check("po_err", 32'(TIMEOUT_ERR), 32'h0);
    check("po_q_empty", 32'(exp_q.size()), 32'h0);

    // Software reset of domain 1: domain 0 stays released.
    SW_RST_REQ = 3'b010;
    e = cyc + 1;
    push(3'b001, e);
    @(negedge CLK);
    SW_RST_REQ = '0;
    check("sw1_busy", 32'(SEQ_BUSY), 32'h1);
    check("sw1_done", 32'(SEQ_DONE), 32'h0);
    push(3'b011, e + STRETCH_CYC + 1);
    push(3'b111, e + STRETCH_CYC + 1 + lat);
    wait_to(e + STRETCH_CYC + 2 * lat);
    check("sw1_run", 32'(SEQ_DONE), 32'h1);
    check("sw1_q_empty", 32'(exp_q.size()), 32'h0);

    // Two requests at once: lowest wins; a request during the sequence is ignored.
    SW_RST_REQ = 3'b110;
    e = cyc + 1;
    push(3'b001, e);
    @(negedge CLK);
    SW_RST_REQ = 3'b100;
    push(3'b011, e + STRETCH_CYC + 1);
    push(3'b111, e + STRETCH_CYC + 1 + lat);
    wait_to(e + 8);
    check("multi_busy", 32'(SEQ_BUSY), 32'h1);
    SW_RST_REQ = '0;
    wait_to(e + STRETCH_CYC + 2 * lat);
    check("multi_run", 32'(SEQ_DONE), 32'h1);
    check("multi_q_empty", 32'(exp_q.size()), 32'h0);

    // GAP_CFG=0: next release follows the synchronized ack immediately.
    GAP_CFG    = 8'd0;
    SW_RST_REQ = 3'b001;
    e = cyc + 1;
    push(3'b000, e);
    @(negedge CLK);
    SW_RST_REQ = '0;
    lat = 2 + SYNC_STAGES;
    push(3'b001, e + STRETCH_CYC + 1);
    push(3'b011, e + STRETCH_CYC + 1 + lat);
    push(3'b111, e + STRETCH_CYC + 1 + 2 * lat);
    wait_to(e + STRETCH_CYC + 2 * lat + lat - 1);
    check("gap0_done_early", 32'(SEQ_DONE), 32'h0);
    wait_to(e + STRETCH_CYC + 2 * lat + lat);
    check("gap0_done", 32'(SEQ_DONE), 32'h1);
    check("gap0_q_empty", 32'(exp_q.size()), 32'h0);

    // GAP_CFG=3, changed while domain 0 sits in GAP: timing must not move.
    GAP_CFG    = 8'd3;
    SW_RST_REQ = 3'b001;
    e = cyc + 1;
    push(3'b000, e);
    @(negedge CLK);
    SW_RST_REQ = '0;
    lat = 2 + SYNC_STAGES + 3;
    push(3'b001, e + STRETCH_CYC + 1);
    push(3'b011, e + STRETCH_CYC + 1 + lat);
    push(3'b111, e + STRETCH_CYC + 1 + 2 * lat);
    wait_to(e + STRETCH_CYC + 1 + SYNC_STAGES + 2);
    GAP_CFG = 8'd9;
    wait_to(e + STRETCH_CYC + 1 + SYNC_STAGES + 4);
    GAP_CFG = 8'd3;
    wait_to(e + STRETCH_CYC + 2 * lat + lat);
    check("midgap_done", 32'(SEQ_DONE), 32'h1);
    check("midgap_q_empty", 32'(exp_q.size()), 32'h0);

    // Ack of an already released domain drops in RUN: no re-sequence.
    GAP_CFG = 8'd2;
    ack_en  = 3'b101;
    repeat (4) @(negedge CLK);
    check("ackdrop_done", 32'(SEQ_DONE), 32'h1);
    check("ackdrop_rst_n", 32'(DOM_RST_N), 32'h7);

    // Domain 1 never acks: timeout after TIMEOUT_CYC, sequence continues.
    SW_RST_REQ = 3'b001;
    e = cyc + 1;
    push(3'b000, e);
    @(negedge CLK);
    SW_RST_REQ = '0;
    lat = 2 + SYNC_STAGES + 2;
    push(3'b001, e + STRETCH_CYC + 1);
    push(3'b011, e + STRETCH_CYC + 1 + lat);
    base = e + STRETCH_CYC + 1 + lat;
    push(3'b111, base + TIMEOUT_CYC + 2 + 1);
    wait_to(base + TIMEOUT_CYC - 1);
    check("to_err_early", 32'(TIMEOUT_ERR), 32'h0);
    wait_to(base + TIMEOUT_CYC);
    check("to_err_set", 32'(TIMEOUT_ERR), 32'h1);
    wait_to(base + TIMEOUT_CYC + 3 + lat - 1);
    check("to_done", 32'(SEQ_DONE), 32'h1);
    check("to_err_run", 32'(TIMEOUT_ERR), 32'h1);
    check("to_q_empty", 32'(exp_q.size()), 32'h0);
    ack_en = '1;

    // Async RST during WAIT_ACK of domain 0, then full restart from domain 0.
    SW_RST_REQ = 3'b001;
    e = cyc + 1;
    push(3'b000, e);
    @(negedge CLK);
    SW_RST_REQ = '0;
    push(3'b001, e + STRETCH_CYC + 1);
    wait_to(e + STRETCH_CYC + 2);
    check("sticky_err", 32'(TIMEOUT_ERR), 32'h1);
    #2;
    RST = 1'b0;
    push(3'b000, e + STRETCH_CYC + 3);
    #1;
    check("arst_rst_n", 32'(DOM_RST_N), 32'h0);
    check("arst_busy", 32'(SEQ_BUSY), 32'h1);
    check("arst_done", 32'(SEQ_DONE), 32'h0);
    check("arst_err", 32'(TIMEOUT_ERR), 32'h0);
    wait_to(e + STRETCH_CYC + 4);
    RST  = 1'b1;
    base = cyc;
    push(3'b001, base + STRETCH_CYC + 1);
    push(3'b011, base + STRETCH_CYC + 1 + lat);
    push(3'b111, base + STRETCH_CYC + 1 + 2 * lat);
    wait_to(base + STRETCH_CYC + 2 * lat + lat);
    check("restart_done", 32'(SEQ_DONE), 32'h1);
    check("restart_err", 32'(TIMEOUT_ERR), 32'h0);
    repeat (2) @(negedge CLK);
    check("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
